// File: rtl/sram_sp_512x56_bank.sv
// sram_sp_512x56_bank: 512x56 single-port synchronous SRAM built from seven 512x8 byte lanes.
// Optional per-lane even parity is enabled by defining SRAM_PARITY_EN.
module sram_sp_512x56_bank #(
    parameter int DEPTH  = 512,
    parameter int ADDR_W = 9,
    parameter int WIDTH  = 56,
    parameter int LANES  = 7
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WIDTH-1:0]  din,
    output logic [WIDTH-1:0]  dout,
    output logic              parity_err
);

    logic [WIDTH-1:0] rd_word;
`ifdef SRAM_PARITY_EN
    logic [LANES-1:0] lane_perr;
`endif

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [7:0] mem [DEPTH];

        // Lane write port; writes are blocked while reset is held.
        always_ff @(posedge clk) begin
            if (resetn && we) begin
                mem[addr] <= din[8*k +: 8];
            end
        end

        assign rd_word[8*k +: 8] = mem[addr];

`ifdef SRAM_PARITY_EN
        logic par [DEPTH];

        // Even-parity bit stored alongside each written byte.
        always_ff @(posedge clk) begin
            if (resetn && we) begin
                par[addr] <= ^din[8*k +: 8];
            end
        end

        assign lane_perr[k] = (^mem[addr]) ^ par[addr];
`endif
    end

    // Registered read port, write-first on write cycles.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            dout <= '0;
        end else if (we) begin
            dout <= din;
        end else begin
            dout <= rd_word;
        end
    end

`ifdef SRAM_PARITY_EN
    // Parity flag travels with dout; cleared on write cycles.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            parity_err <= 1'b0;
        end else if (we) begin
            parity_err <= 1'b0;
        end else begin
            parity_err <= |lane_perr;
        end
    end
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_sram_sp_512x56_bank.sv
// tb_sram_sp_512x56_bank: directed vector bench for sram_sp_512x56_bank.
// Table-driven write/read vectors plus hand sequences for reset corners.
module tb_sram_sp_512x56_bank;

    logic        clk;
    logic        resetn;
    logic        we;
    logic [8:0]  addr;
    logic [55:0] din;
    logic [55:0] dout;
    logic        parity_err;

    int nvec;
    int nerr;

    typedef struct {
        logic        we;
        logic [8:0]  addr;
        logic [55:0] din;
        logic [55:0] exp;
    } vec_t;

    vec_t vt [12];

    sram_sp_512x56_bank dut (
        .clk        (clk),
        .resetn     (resetn),
        .we         (we),
        .addr       (addr),
        .din        (din),
        .dout       (dout),
        .parity_err (parity_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [55:0] act,
                       input logic [55:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %b want %b", name, act, exp);
        end
    endtask

    task automatic apply(input logic w, input logic [8:0] a,
                         input logic [55:0] d);
        @(negedge clk);
        we   = w;
        addr = a;
        din  = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        nvec   = 0;
        nerr   = 0;
        resetn = 1'b0;
        we     = 1'b0;
        addr   = '0;
        din    = '0;

        vt[0]  = '{1'b1, 9'h000, 56'h12_3456_789A_BCDE, 56'h12_3456_789A_BCDE};
        vt[1]  = '{1'b1, 9'h1FF, 56'hA5_A5A5_A5A5_A5A5, 56'hA5_A5A5_A5A5_A5A5};
        vt[2]  = '{1'b0, 9'h000, 56'h0,                 56'h12_3456_789A_BCDE};
        vt[3]  = '{1'b0, 9'h1FF, 56'h0,                 56'hA5_A5A5_A5A5_A5A5};
        vt[4]  = '{1'b1, 9'h003, 56'h00_0000_DEAD_BEEF, 56'h00_0000_DEAD_BEEF};
        vt[5]  = '{1'b1, 9'h003, 56'h01_0000_0000_0001, 56'h01_0000_0000_0001};
        vt[6]  = '{1'b0, 9'h003, 56'h0,                 56'h01_0000_0000_0001};
        vt[7]  = '{1'b1, 9'h007, 56'h01_0203_0405_0607, 56'h01_0203_0405_0607};
        vt[8]  = '{1'b0, 9'h005, 56'h0,                 56'h0};
        vt[9]  = '{1'b0, 9'h1FF, 56'h0,                 56'hA5_A5A5_A5A5_A5A5};
        vt[10] = '{1'b1, 9'h00A, 56'h00_0000_0000_CAFE, 56'h00_0000_0000_CAFE};
        vt[11] = '{1'b0, 9'h000, 56'h0,                 56'h12_3456_789A_BCDE};

        #12;
        chk("reset_dout", dout, 56'h0);
        chk1("reset_perr", parity_err, 1'b0);
        @(negedge clk);
        resetn = 1'b1;

        // Clear addr 5 so the suppressed write below has a known baseline.
        apply(1'b1, 9'd5, 56'h0);
        chk("clear5", dout, 56'h0);

        // Write attempted throughout reset must not land.
        @(negedge clk);
        resetn = 1'b0;
        we     = 1'b1;
        addr   = 9'd5;
        din    = 56'hFF_FFFF_FFFF_FFFF;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("rst_hold_dout", dout, 56'h0);
        end
        @(negedge clk);
        resetn = 1'b1;
        we     = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_suppress5", dout, 56'h0);

        for (int i = 0; i < 12; i++) begin
            apply(vt[i].we, vt[i].addr, vt[i].din);
            chk($sformatf("vec%0d", i), dout, vt[i].exp);
            chk1($sformatf("vec%0d_perr", i), parity_err, 1'b0);
        end

        // Each lane of addr 7 carries its own byte.
        apply(1'b0, 9'd7, 56'h0);
        for (int k = 0; k < 7; k++) begin
            chk($sformatf("lane%0d", k), {48'h0, dout[8*k +: 8]},
                56'(7 - k));
        end

        // Half-cycle reset pulse clears dout but keeps the array.
        apply(1'b0, 9'd10, 56'h0);
        chk("pre_pulse", dout, 56'h00_0000_0000_CAFE);
        resetn = 1'b0;
        #2;
        chk("pulse_dout", dout, 56'h0);
        #2;
        resetn = 1'b1;
        @(posedge clk);
        #1;
        chk("post_pulse", dout, 56'h00_0000_0000_CAFE);

`ifdef SRAM_PARITY_EN
        apply(1'b1, 9'd20, 56'h80);
        apply(1'b0, 9'd20, 56'h0);
        chk1("par_ok", parity_err, 1'b0);
        force dut.g_lane[0].mem[20] = 8'h81;
        apply(1'b0, 9'd20, 56'h0);
        chk1("par_bad", parity_err, 1'b1);
        release dut.g_lane[0].mem[20];
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
